sequential_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider; inverse companion of the shift-add

---
 rtl/sequential_divider.sv | 154 +++++++++++++++
 tb/tb_sequential_divider.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start-pulse in, registered result out.
// Optional feature macro: DIV_ZERO_DETECT_EN (early finish on a zero divisor, drives div_by_zero).
module sequential_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] step_r, step_q;
`ifdef DIV_ZERO_DETECT_EN
  logic             dbz_q, dbz_d;
`endif

  // One restoring step. The partial remainder always stays below the divisor
  // (or equals a dividend prefix when the divisor is zero), so it fits in WIDTH
  // bits between steps; only the shifted trial value needs the extra bit.
  function automatic logic [2*WIDTH-1:0] restore_step(
    input logic [WIDTH-1:0] r,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH:0]   rs;
    logic [WIDTH-1:0] qs;
    rs = {r, q[WIDTH-1]};
    qs = {q[WIDTH-2:0], 1'b0};
    if (rs >= {1'b0, d}) begin
      rs    = rs - {1'b0, d};
      qs[0] = 1'b1;
    end
    return {rs[WIDTH-1:0], qs};
  endfunction

  always_comb begin
    {step_r, step_q} = restore_step(r_q, q_q, d_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          state_d = INIT;
`ifdef DIV_ZERO_DETECT_EN
          dbz_d   = 1'b0;
`endif
        end
      end
      INIT: begin
        r_d     = '0;
        cnt_d   = '0;
        state_d = ITER;
`ifdef DIV_ZERO_DETECT_EN
        if (d_q == '0) begin
          quo_d   = '1;
          rem_d   = q_q;
          dbz_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      ITER: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          quo_d   = step_q;
          rem_d   = step_r;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  // Working registers are always reloaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    r_q <= r_d;
    q_q <= q_d;
    d_q <= d_d;
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign busy      = (state_q == INIT) || (state_q == ITER);
  assign done      = (state_q == DONE);
`ifdef DIV_ZERO_DETECT_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider (WIDTH=4): directed cases plus random operands vs. a plain-arithmetic model.
module tb_sequential_divider;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  sequential_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one division, then check latency, busy length and results against arithmetic.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold, input string tag);
    int           edges;
    int           busy_cyc;
    bit           seen;
    int           exp_lat;
    logic [W-1:0] eq, er;
    logic         edbz;
    eq = (b != 0) ? W'(a / b) : {W{1'b1}};
    er = (b != 0) ? W'(a % b) : a;
`ifdef DIV_ZERO_DETECT_EN
    edbz    = (b == 0);
    exp_lat = (b == 0) ? 2 : W + 2;
`else
    edbz    = 1'b0;
    exp_lat = W + 2;
`endif
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom);
    edges = 1; busy_cyc = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      @(posedge clk);
      edges++;
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, edges, exp_lat);
    chk({tag, " busy_cycles"}, busy_cyc, exp_lat - 1);
    chk({tag, " quotient"}, 32'(quotient), 32'(eq));
    chk({tag, " remainder"}, 32'(remainder), 32'(er));
    chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edbz));
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    if (hold) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk({tag, " no_retrigger_busy"}, 32'(busy), 32'd0);
      chk({tag, " no_retrigger_done"}, 32'(done), 32'd0);
      chk({tag, " held_quotient"}, 32'(quotient), 32'(eq));
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(4'd13, 4'd3, 1'b0, "13/3");
    run_op(4'd15, 4'd1, 1'b0, "15/1");
    run_op(4'd6, 4'd7, 1'b0, "6/7");
    repeat (3) @(negedge clk);
    chk("held quotient", 32'(quotient), 32'd0);
    chk("held remainder", 32'(remainder), 32'd6);

    run_op(4'd11, 4'd2, 1'b1, "hold 11/2");
    run_op(4'd9, 4'd0, 1'b0, "9/0");
    run_op(4'd13, 4'd3, 1'b0, "clear_dbz 13/3");

    // Reset asserted in the middle of the iteration phase.
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst quotient", 32'(quotient), 32'd0);
    chk("midrst remainder", 32'(remainder), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("after_rst idle", 32'(busy), 32'd0);
    run_op(4'd13, 4'd3, 1'b0, "post_rst 13/3");

    run_op(4'd0, 4'd5, 1'b0, "0/5");
    run_op(4'd15, 4'd15, 1'b0, "15/15");
    run_op(4'd15, 4'd0, 1'b0, "15/0");

    for (int n = 0; n < 25; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d %0d/%0d", n, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
